boron_inv_sbox_layer: RTL

BORON_INV_SBOX_LAYER -- requirements
Module: boron_inv_sbox_layer

---
 rtl/boron_inv_sbox_layer.sv | 108 ++++++++++
 1 files changed

// File: rtl/boron_inv_sbox_layer.sv
// Nibble-serial 4-bit S-box layer over a 64-bit state, forward or inverse per block.
// LANES nibbles are substituted per cycle; 16/LANES cycles per block.
module boron_inv_sbox_layer #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        dir,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    localparam int GROUPS = 16 / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(GROUPS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUB  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_dir;
    logic [63:0]   r_work;
    logic          r_rst_done;
    logic [63:0]   w_next_work;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
            4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
            4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
            4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hA;  4'h1: y = 4'h3;  4'h2: y = 4'h9;  4'h3: y = 4'hE;
            4'h4: y = 4'h1;  4'h5: y = 4'hD;  4'h6: y = 4'hF;  4'h7: y = 4'h4;
            4'h8: y = 4'hC;  4'h9: y = 4'h5;  4'hA: y = 4'h7;  4'hB: y = 4'h2;
            4'hC: y = 4'h6;  4'hD: y = 4'h8;  4'hE: y = 4'h0;  default: y = 4'hB;
        endcase
        return y;
    endfunction

    // NOTE: the default copy of r_work before the loop keeps every bit assigned on every path, so no latch is inferred.
    always_comb begin
        w_next_work = r_work;
        for (int j = 0; j < LANES; j++) begin
            w_next_work[(int'(r_cnt) * LANES + j) * 4 +: 4] =
                r_dir ? sbox_inv(r_work[(int'(r_cnt) * LANES + j) * 4 +: 4])
                      : sbox_fwd(r_work[(int'(r_cnt) * LANES + j) * 4 +: 4]);
        end
    end

    // NOTE: non-blocking assignments keep every register reading pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_dir      <= 1'b0;
            r_work     <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_work  <= in_data;
                        r_dir   <= dir;
                        r_cnt   <= '0;
                        r_state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    r_work <= w_next_work;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // in_ready is held low until the first edge after reset release.
    assign in_ready  = (r_state == ST_IDLE) && r_rst_done;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state == ST_SUB) || (r_state == ST_DONE);
    assign out_data  = r_work;

endmodule
